// File: rtl/protocol_arbiter.sv
// Round-robin arbiter sharing one req/ack/ready downstream slave between NUM_REQ requesters.
// Optional WAIT_ACK timeout/abort is enabled by defining PROTOCOL_ARB_TIMEOUT_EN.
module protocol_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        s_req,
  input  logic [NUM_REQ*DATA_W-1:0] s_data,
  output logic [NUM_REQ-1:0]        s_grant,
  output logic [NUM_REQ-1:0]        s_ack,
  output logic [NUM_REQ-1:0]        s_err,
  output logic                      m_req,
  output logic [DATA_W-1:0]         m_data,
  input  logic                      m_ack,
  input  logic                      m_ready,
  output logic                      busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("protocol_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {IDLE, ARB, WAIT_ACK, WAIT_REL} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [PTR_W-1:0]     win_idx, scan_idx, rr_next;
  logic                 win_found;
  logic                 owner_req;
  logic [NUM_REQ-1:0]   grant_d;
  logic                 m_req_d;
  logic [DATA_W-1:0]    m_data_d;
  logic [DATA_W-1:0]    req_data [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_data[g] = s_data[g*DATA_W +: DATA_W];
  end

  assign owner_req = |(s_req & s_grant);
  assign rr_next   = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
  assign s_ack     = s_grant & {NUM_REQ{m_ack}};
  assign busy      = (state_q != IDLE);

  // First active request scanning upward from rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!win_found && s_req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

`ifdef PROTOCOL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] err_d;
`else
  assign s_err = '0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = s_grant;
    m_req_d  = m_req;
    m_data_d = m_data;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
`ifdef PROTOCOL_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = '0;
`endif
    case (state_q)
      IDLE: begin
        if (m_ready && (|s_req)) state_d = ARB;
      end
      ARB: begin
        if (win_found) begin
          state_d  = WAIT_ACK;
          grant_d  = NUM_REQ'(1) << win_idx;
          m_data_d = req_data[win_idx];
          m_req_d  = 1'b1;
          owner_d  = win_idx;
`ifdef PROTOCOL_ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_ACK: begin
        // An owner that already dropped its request is released on the ack itself
        if (m_ack) begin
          if (owner_req) begin
            state_d = WAIT_REL;
          end else begin
            state_d  = IDLE;
            m_req_d  = 1'b0;
            grant_d  = '0;
            rr_ptr_d = rr_next;
          end
        end
`ifdef PROTOCOL_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d  = IDLE;
          m_req_d  = 1'b0;
          grant_d  = '0;
          rr_ptr_d = rr_next;
          err_d    = s_grant;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      WAIT_REL: begin
        if (!owner_req) begin
          state_d  = IDLE;
          m_req_d  = 1'b0;
          grant_d  = '0;
          rr_ptr_d = rr_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s_grant  <= '0;
      m_req    <= 1'b0;
      m_data   <= '0;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      s_grant  <= grant_d;
      m_req    <= m_req_d;
      m_data   <= m_data_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

`ifdef PROTOCOL_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      s_err <= '0;
    end else begin
      cnt_q <= cnt_d;
      s_err <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_protocol_arbiter.sv
// Self-checking bench for protocol_arbiter: directed scenarios plus randomized transactions
// checked against a round-robin reference model.
module tb_protocol_arbiter;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int TCYC = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    s_req;
  logic [N*DW-1:0] s_data;
  logic [N-1:0]    s_grant, s_ack, s_err;
  logic            m_req;
  logic [DW-1:0]   m_data;
  logic            m_ack, m_ready, busy;

  int checks = 0;
  int errors = 0;
  int exp_rr = 0;

  always #5 clk = ~clk;

  protocol_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .rst_n(rst_n), .s_req(s_req), .s_data(s_data),
    .s_grant(s_grant), .s_ack(s_ack), .s_err(s_err),
    .m_req(m_req), .m_data(m_data), .m_ack(m_ack), .m_ready(m_ready), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: first requester at or after ptr, wrapping
  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  function automatic logic [DW-1:0] lane(input int i);
    return s_data[i*DW +: DW];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; s_req = '1; s_data = $urandom; m_ack = 1'b1; m_ready = 1'b1;
    tick(); tick();
    checks++; if (s_grant !== '0) begin errors++; $display("FAIL reset_grant: got %b want 0000", s_grant); end
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL reset_m_req: got %b want 0", m_req); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h want 00", m_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (s_err !== '0) begin errors++; $display("FAIL reset_s_err: got %b want 0000", s_err); end
    checks++; if (s_ack !== '0) begin errors++; $display("FAIL reset_s_ack: got %b want 0000", s_ack); end
    s_req = '0; m_ack = 1'b0; rst_n = 1'b1; exp_rr = 0;
    tick();
  endtask

  task automatic test_single();
    s_data = $urandom; s_data[2*DW +: DW] = 8'hA5; s_req = 4'b0100; m_ready = 1'b1;
    tick();
    checks++; if (m_req !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_arb: got m_req=%b busy=%b want 0 1", m_req, busy); end
    tick();
    checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL single_m_req: got %b want 1", m_req); end
    checks++; if (s_grant !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", s_grant); end
    checks++; if (m_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", m_data); end
    m_ack = 1'b1; #1;
    checks++; if (s_ack !== 4'b0100) begin errors++; $display("FAIL single_s_ack: got %b want 0100", s_ack); end
    tick();
    m_ack = 1'b0;
    checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL single_hold_rel: got %b want 1", m_req); end
    s_req = '0;
    tick();
    checks++; if (m_req !== 1'b0 || s_grant !== '0 || busy !== 1'b0) begin errors++; $display("FAIL single_release: got m_req=%b grant=%b busy=%b want 0 0000 0", m_req, s_grant, busy); end
    exp_rr = 3;
  endtask

  task automatic test_round_robin();
    int w;
    s_req = '0; rst_n = 1'b0; tick(); rst_n = 1'b1; exp_rr = 0;
    s_data = $urandom; s_req = '1; m_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      w = pick(s_req, exp_rr);
      tick(); tick();
      checks++; if (s_grant !== onehot(w)) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", g, s_grant, onehot(w)); end
      checks++; if (m_data !== lane(w)) begin errors++; $display("FAIL rr_data%0d: got %h want %h", g, m_data, lane(w)); end
      m_ack = 1'b1; tick(); m_ack = 1'b0;
      s_req = s_req & ~onehot(w);
      tick();
      checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL rr_release%0d: got %b want 0", g, m_req); end
      exp_rr = (w + 1) % N;
      s_req = '1;
    end
    s_req = '0;
    tick();
  endtask

  task automatic test_not_ready();
    int w;
    m_ready = 1'b0; s_req = 4'b0010; m_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (busy !== 1'b0 || s_grant !== '0 || s_ack !== '0) begin errors++; $display("FAIL notready%0d: got busy=%b grant=%b ack=%b want 0 0000 0000", c, busy, s_grant, s_ack); end
    end
    m_ack = 1'b0; m_ready = 1'b1;
    w = pick(s_req, exp_rr);
    tick();
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL notready_arb: got %b want 0", m_req); end
    tick();
    checks++; if (m_req !== 1'b1 || s_grant !== onehot(w)) begin errors++; $display("FAIL notready_grant: got m_req=%b grant=%b want 1 %b", m_req, s_grant, onehot(w)); end
    m_ack = 1'b1; tick(); m_ack = 1'b0; s_req = '0; tick();
    exp_rr = (w + 1) % N;
  endtask

  task automatic test_arb_drop();
    int w;
    s_req = 4'b1000;
    tick();
    s_req = '0;
    tick();
    checks++; if (busy !== 1'b0 || s_grant !== '0 || m_req !== 1'b0) begin errors++; $display("FAIL arbdrop: got busy=%b grant=%b m_req=%b want 0 0000 0", busy, s_grant, m_req); end
    s_req = '1; s_data = $urandom;
    w = pick(s_req, exp_rr);
    tick(); tick();
    checks++; if (s_grant !== onehot(w)) begin errors++; $display("FAIL arbdrop_ptr: got %b want %b", s_grant, onehot(w)); end
    m_ack = 1'b1; tick(); m_ack = 1'b0; s_req = '0; tick();
    exp_rr = (w + 1) % N;
  endtask

  task automatic test_data_latch();
    int w;
    s_data = $urandom; s_data[0 +: DW] = 8'h55; s_req = 4'b0001;
    w = pick(s_req, exp_rr);
    tick(); tick();
    checks++; if (m_data !== 8'h55) begin errors++; $display("FAIL latch_initial: got %h want 55", m_data); end
    m_ack = 1'b1; tick(); m_ack = 1'b0;
    s_data[0 +: DW] = 8'hAA;
    tick();
    checks++; if (m_data !== 8'h55 || m_req !== 1'b1) begin errors++; $display("FAIL latch_hold: got data=%h m_req=%b want 55 1", m_data, m_req); end
    s_req = '0; tick();
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL latch_release: got %b want 0", m_req); end
    exp_rr = (w + 1) % N;
  endtask

  task automatic test_random();
    int w, stall, dly, hold;
    logic early;
    logic [DW-1:0] exp_d;
    for (int it = 0; it < 40; it++) begin
      s_req = N'($urandom_range(1, (1 << N) - 1)); s_data = $urandom;
      stall = $urandom_range(0, 2);
      m_ready = 1'b0;
      for (int c = 0; c < stall; c++) begin
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd%0d_stall: got busy=%b want 0", it, busy); end
      end
      m_ready = 1'b1;
      w = pick(s_req, exp_rr); exp_d = lane(w);
      tick(); tick();
      checks++; if (s_grant !== onehot(w) || m_req !== 1'b1 || m_data !== exp_d) begin errors++; $display("FAIL rnd%0d_grant: got grant=%b m_req=%b data=%h want %b 1 %h", it, s_grant, m_req, m_data, onehot(w), exp_d); end
      s_data = $urandom;
      early = ($urandom_range(0, 3) == 0);
      if (early) s_req = s_req & ~onehot(w);
      dly = $urandom_range(0, 3);
      for (int c = 0; c < dly; c++) begin
        tick();
        checks++; if (m_req !== 1'b1 || m_data !== exp_d) begin errors++; $display("FAIL rnd%0d_wait: got m_req=%b data=%h want 1 %h", it, m_req, m_data, exp_d); end
      end
      m_ack = 1'b1; #1;
      checks++; if (s_ack !== onehot(w)) begin errors++; $display("FAIL rnd%0d_ack: got %b want %b", it, s_ack, onehot(w)); end
      tick(); m_ack = 1'b0;
      if (!early) begin
        hold = $urandom_range(0, 2);
        for (int c = 0; c < hold; c++) begin
          s_req = N'($urandom) | onehot(w);
          tick();
          checks++; if (m_req !== 1'b1 || s_grant !== onehot(w)) begin errors++; $display("FAIL rnd%0d_rel: got m_req=%b grant=%b want 1 %b", it, m_req, s_grant, onehot(w)); end
        end
        s_req = s_req & ~onehot(w);
        tick();
      end
      checks++; if (m_req !== 1'b0 || s_grant !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rnd%0d_done: got m_req=%b grant=%b busy=%b want 0 0000 0", it, m_req, s_grant, busy); end
      exp_rr = (w + 1) % N;
    end
    s_req = '0; m_ready = 1'b1;
    tick();
  endtask

  task automatic test_timeout();
    int w;
    s_req = '1; s_data = $urandom; m_ack = 1'b0;
    w = pick(s_req, exp_rr);
    tick(); tick();
    checks++; if (s_grant !== onehot(w)) begin errors++; $display("FAIL to_grant: got %b want %b", s_grant, onehot(w)); end
`ifdef PROTOCOL_ARB_TIMEOUT_EN
    for (int c = 1; c < TCYC; c++) begin
      tick();
      checks++; if (m_req !== 1'b1 || s_err !== '0) begin errors++; $display("FAIL to_wait%0d: got m_req=%b err=%b want 1 0000", c, m_req, s_err); end
    end
    tick();
    checks++; if (m_req !== 1'b0 || s_grant !== '0 || s_err !== onehot(w)) begin errors++; $display("FAIL to_abort: got m_req=%b grant=%b err=%b want 0 0000 %b", m_req, s_grant, s_err, onehot(w)); end
    exp_rr = (w + 1) % N;
    w = pick(s_req, exp_rr);
    tick();
    checks++; if (s_err !== '0) begin errors++; $display("FAIL to_err_pulse: got %b want 0000", s_err); end
    tick();
    checks++; if (s_grant !== onehot(w)) begin errors++; $display("FAIL to_next_grant: got %b want %b", s_grant, onehot(w)); end
`else
    repeat (100) tick();
    checks++; if (m_req !== 1'b1 || s_grant !== onehot(w) || s_err !== '0) begin errors++; $display("FAIL to_still_waiting: got m_req=%b grant=%b err=%b want 1 %b 0000", m_req, s_grant, s_err, onehot(w)); end
`endif
    m_ack = 1'b1; tick(); m_ack = 1'b0; s_req = '0; tick();
    exp_rr = (w + 1) % N;
  endtask

  task automatic test_reset_midop();
    s_req = 4'b0100; s_data = $urandom;
    tick(); tick();
    checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL midop_setup: got %b want 1", m_req); end
    #2 rst_n = 1'b0; #1;
    checks++; if (m_req !== 1'b0 || s_grant !== '0 || busy !== 1'b0) begin errors++; $display("FAIL midop_reset: got m_req=%b grant=%b busy=%b want 0 0000 0", m_req, s_grant, busy); end
    s_req = '1;
    tick();
    rst_n = 1'b1; exp_rr = 0;
    tick(); tick();
    checks++; if (s_grant !== onehot(pick(s_req, exp_rr))) begin errors++; $display("FAIL midop_ptr: got %b want %b", s_grant, onehot(pick(s_req, exp_rr))); end
    m_ack = 1'b1; tick(); m_ack = 1'b0; s_req = '0; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; s_req = '0; s_data = '0; m_ack = 1'b0; m_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_not_ready();
    test_arb_drop();
    test_data_latch();
    test_random();
    test_timeout();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
